// File: rtl/aibcr3_io_pwrseq.sv
// Power-up / power-down sequencer for one AIB IO buffer: orders pad reset,
// digital reset, drive enables and weak pulls under POR and a req/ack handshake.
module aibcr3_io_pwrseq #(
  parameter int unsigned PADRST_CYC = 16,
  parameter int unsigned RSTB_CYC   = 8,
  parameter int unsigned WKPULL_CYC = 4
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       ipor,
  input  logic       ien_req,
  input  logic       imode_tx,
  input  logic [1:0] ipdrv_cfg,
  input  logic [1:0] indrv_cfg,
  input  logic [2:0] irxen_cfg,
  output logic       oen_ack,
  output logic       obusy,
  output logic [2:0] ostate,
  output logic       opadrstb,
  output logic       orstb,
  output logic       otxen,
  output logic [2:0] orxen,
  output logic [1:0] opdrv,
  output logic [1:0] ondrv,
  output logic       oweakpd,
  output logic       oweakpu
);

  localparam int unsigned MAX_AB  = (PADRST_CYC > RSTB_CYC) ? PADRST_CYC : RSTB_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > WKPULL_CYC) ? MAX_AB : WKPULL_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_PADRST = 3'd1,
    S_PADREL = 3'd2,
    S_DRVON  = 3'd3,
    S_ON     = 3'd4,
    S_DRAIN  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q;
  logic          tx_q, tx_d;
  logic [1:0]    pdrv_q, pdrv_d, ndrv_q, ndrv_d;
  logic [2:0]    rxen_q, rxen_d;
  logic          padrstb_d, rstb_d, txen_d, weakpd_d;
  logic [2:0]    orxen_d;
  logic [1:0]    opdrv_d, ondrv_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    tx_d    = tx_q;
    pdrv_d  = pdrv_q;
    ndrv_d  = ndrv_q;
    rxen_d  = rxen_q;

    unique case (state_q)
      S_OFF: begin
        if (req_q && !ipor) begin
          state_d = S_PADRST;
          cnt_d   = CW'(PADRST_CYC - 1);
          tx_d    = imode_tx;
          pdrv_d  = ipdrv_cfg;
          ndrv_d  = indrv_cfg;
          rxen_d  = irxen_cfg;
        end
      end
      S_PADRST: begin
        if (!req_q) begin
          state_d = S_DRAIN;
          cnt_d   = CW'(WKPULL_CYC - 1);
        end else if (cnt_q == '0) begin
          state_d = S_PADREL;
          cnt_d   = CW'(RSTB_CYC - 1);
        end
      end
      S_PADREL: begin
        if (!req_q) begin
          state_d = S_DRAIN;
          cnt_d   = CW'(WKPULL_CYC - 1);
        end else if (cnt_q == '0) begin
          state_d = S_DRVON;
          cnt_d   = CW'(WKPULL_CYC - 1);
        end
      end
      S_DRVON: begin
        if (!req_q) begin
          state_d = S_DRAIN;
          cnt_d   = CW'(WKPULL_CYC - 1);
        end else if (cnt_q == '0) begin
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (!req_q) begin
          state_d = S_DRAIN;
          cnt_d   = CW'(WKPULL_CYC - 1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase

    // Abort overrides every transition above, including a pending latch.
    if (irst || ipor) state_d = S_OFF;

    // Outputs are decoded from the next state so they register alongside it.
    padrstb_d = 1'b0;
    rstb_d    = 1'b0;
    txen_d    = 1'b0;
    orxen_d   = '0;
    opdrv_d   = '0;
    ondrv_d   = '0;
    weakpd_d  = 1'b1;
    unique case (state_d)
      S_PADREL: padrstb_d = 1'b1;
      S_DRVON, S_ON: begin
        padrstb_d = 1'b1;
        rstb_d    = 1'b1;
        weakpd_d  = (state_d != S_ON);
        if (tx_d) begin
          txen_d  = 1'b1;
          opdrv_d = pdrv_d;
          ondrv_d = ndrv_d;
        end else begin
          orxen_d = rxen_d;
        end
      end
      S_DRAIN: begin
        padrstb_d = opadrstb;
        rstb_d    = orstb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      tx_q     <= 1'b0;
      pdrv_q   <= '0;
      ndrv_q   <= '0;
      rxen_q   <= '0;
      oen_ack  <= 1'b0;
      obusy    <= 1'b0;
      ostate   <= '0;
      opadrstb <= 1'b0;
      orstb    <= 1'b0;
      otxen    <= 1'b0;
      orxen    <= '0;
      opdrv    <= '0;
      ondrv    <= '0;
      oweakpd  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= ien_req;
      tx_q     <= tx_d;
      pdrv_q   <= pdrv_d;
      ndrv_q   <= ndrv_d;
      rxen_q   <= rxen_d;
      oen_ack  <= (state_d == S_ON);
      obusy    <= (state_d != S_OFF) && (state_d != S_ON);
      ostate   <= state_d;
      opadrstb <= padrstb_d;
      orstb    <= rstb_d;
      otxen    <= txen_d;
      orxen    <= orxen_d;
      opdrv    <= opdrv_d;
      ondrv    <= ondrv_d;
      oweakpd  <= weakpd_d;
    end
  end

  assign oweakpu = 1'b0;

endmodule
